inst_queue: RTL and testbench

- Circular instruction buffer and issue scheduler between the instruction fetcher and the decoder.
- Accepts fetched {inst, pc, predicted-jump} triples and holds them in order.
- Releases one entry per cycle to the decoder when the downstream ROB and the target unit (RS or LSB) can accept it.
- Discards all contents on a branch-mispredict flush.

---
 rtl/inst_queue.sv | 96 +++++++++
 tb/tb_inst_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Circular instruction buffer between the fetcher and the decoder. It issues
// the head entry in order once the ROB and the target unit (RS or LSB) have room.
module inst_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        iINF_en,
  input  logic [31:0] iINF_inst,
  input  logic [31:0] iINF_pc,
  input  logic        iINF_pd,
  output logic        oINF_full,
  input  logic        iROB_full,
  input  logic        iRS_full,
  input  logic        iLSB_full,
  input  logic        iJP_wrong,
  output logic        oDEC_en,
  output logic [31:0] oDEC_inst,
  output logic [31:0] oDEC_pc,
  output logic        oDEC_pd,
  output logic        oIQ_empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [6:0]      OP_LOAD  = 7'b0000011;
  localparam logic [6:0]      OP_STORE = 7'b0100011;

  logic [64:0]       mem [DEPTH];
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;

  logic [64:0]       head_entry;
  logic              head_is_mem;
  logic              unit_ok;
  logic              active;
  logic              pop;
  logic              push;

  assign head_entry  = mem[head];
  assign head_is_mem = (head_entry[6:0] == OP_LOAD) || (head_entry[6:0] == OP_STORE);
  assign oINF_full   = (count == FULL_CNT);
  assign oIQ_empty   = (count == '0);

  // Reset and flush both suppress any movement; rdy low freezes everything.
  always_comb begin
    active  = rdy && !iJP_wrong && !rst;
    unit_ok = head_is_mem ? !iLSB_full : !iRS_full;
    pop     = active && (count != '0) && !iROB_full && unit_ok;
    push    = active && iINF_en && ((count != FULL_CNT) || pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= {iINF_pd, iINF_pc, iINF_inst};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      oDEC_en   <= 1'b0;
      oDEC_inst <= '0;
      oDEC_pc   <= '0;
      oDEC_pd   <= 1'b0;
    end else if (iJP_wrong) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      oDEC_en <= 1'b0;
    end else if (rdy) begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      oDEC_en <= pop;
      if (pop) begin
        oDEC_inst <= head_entry[31:0];
        oDEC_pc   <= head_entry[63:32];
        oDEC_pd   <= head_entry[64];
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue; expected values are hand-computed constants.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        iINF_en;
  logic [31:0] iINF_inst, iINF_pc;
  logic        iINF_pd;
  logic        oINF_full;
  logic        iROB_full, iRS_full, iLSB_full, iJP_wrong;
  logic        oDEC_en;
  logic [31:0] oDEC_inst, oDEC_pc;
  logic        oDEC_pd;
  logic        oIQ_empty;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LW  = 32'h0000_2083;
  localparam logic [31:0] ADD = 32'h0020_81b3;
  localparam logic [31:0] SW  = 32'h0011_2023;

  inst_queue #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .iINF_en(iINF_en), .iINF_inst(iINF_inst), .iINF_pc(iINF_pc), .iINF_pd(iINF_pd),
    .oINF_full(oINF_full),
    .iROB_full(iROB_full), .iRS_full(iRS_full), .iLSB_full(iLSB_full),
    .iJP_wrong(iJP_wrong),
    .oDEC_en(oDEC_en), .oDEC_inst(oDEC_inst), .oDEC_pc(oDEC_pc), .oDEC_pd(oDEC_pd),
    .oIQ_empty(oIQ_empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] pc, input logic [31:0] inst,
                       input logic pd);
    iINF_en   = en;
    iINF_pc   = pc;
    iINF_inst = inst;
    iINF_pd   = pd;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    iROB_full = 1'b0; iRS_full = 1'b0; iLSB_full = 1'b0; iJP_wrong = 1'b0;
    drive(1'b0, '0, '0, 1'b0);

    // Reset state
    step(); step();
    check("rst_en", 32'(oDEC_en), 32'd0);
    check("rst_inst", oDEC_inst, 32'd0);
    check("rst_pc", oDEC_pc, 32'd0);
    check("rst_pd", 32'(oDEC_pd), 32'd0);
    check("rst_empty", 32'(oIQ_empty), 32'd1);
    check("rst_full", 32'(oINF_full), 32'd0);
    rst = 1'b0;

    // Three pushes, two-cycle latency, in-order issue
    drive(1'b1, 32'h0, NOP, 1'b0); step();
    check("t1_en0", 32'(oDEC_en), 32'd0);
    check("t1_notempty", 32'(oIQ_empty), 32'd0);
    drive(1'b1, 32'h4, NOP, 1'b1); step();
    check("t1_en_a", 32'(oDEC_en), 32'd1);
    check("t1_pc_a", oDEC_pc, 32'h0);
    check("t1_pd_a", 32'(oDEC_pd), 32'd0);
    drive(1'b1, 32'h8, NOP, 1'b0); step();
    check("t1_en_b", 32'(oDEC_en), 32'd1);
    check("t1_pc_b", oDEC_pc, 32'h4);
    check("t1_pd_b", 32'(oDEC_pd), 32'd1);
    drive(1'b0, '0, '0, 1'b0); step();
    check("t1_en_c", 32'(oDEC_en), 32'd1);
    check("t1_pc_c", oDEC_pc, 32'h8);
    check("t1_empty", 32'(oIQ_empty), 32'd1);
    step();
    check("t1_en_off", 32'(oDEC_en), 32'd0);
    check("t1_pc_hold", oDEC_pc, 32'h8);

    // Fill to 16 behind a full ROB; 17th push dropped; push+pop at full
    iROB_full = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), NOP, 1'b0); step();
      if (i == 14) check("t2_full15", 32'(oINF_full), 32'd0);
    end
    check("t2_full16", 32'(oINF_full), 32'd1);
    check("t2_noissue", 32'(oDEC_en), 32'd0);
    drive(1'b1, 32'hDEAD, NOP, 1'b0); step();
    check("t2_full17", 32'(oINF_full), 32'd1);
    iROB_full = 1'b0;
    drive(1'b1, 32'h1040, NOP, 1'b0); step();
    check("t2_pp_en", 32'(oDEC_en), 32'd1);
    check("t2_pp_pc", oDEC_pc, 32'h1000);
    check("t2_pp_full", 32'(oINF_full), 32'd1);
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      step();
      check("t2_drain_en", 32'(oDEC_en), 32'd1);
      check("t2_drain_pc", oDEC_pc, 32'h1000 + 32'(4 * i));
    end
    step();
    check("t2_end_en", 32'(oDEC_en), 32'd0);
    check("t2_end_empty", 32'(oIQ_empty), 32'd1);

    // Load at head blocked by LSB; younger add waits behind it
    iLSB_full = 1'b1;
    drive(1'b1, 32'h300, LW, 1'b0); step();
    drive(1'b1, 32'h304, ADD, 1'b0); step();
    check("t3_lw_blk", 32'(oDEC_en), 32'd0);
    drive(1'b0, '0, '0, 1'b0); step();
    check("t3_add_blk", 32'(oDEC_en), 32'd0);
    iLSB_full = 1'b0; step();
    check("t3_lw_en", 32'(oDEC_en), 32'd1);
    check("t3_lw_inst", oDEC_inst, LW);
    check("t3_lw_pc", oDEC_pc, 32'h300);
    step();
    check("t3_add_en", 32'(oDEC_en), 32'd1);
    check("t3_add_inst", oDEC_inst, ADD);
    // Store ignores a full RS; add behind it waits on the RS
    iRS_full = 1'b1;
    drive(1'b1, 32'h310, SW, 1'b0); step();
    drive(1'b1, 32'h314, ADD, 1'b0); step();
    check("t3_sw_en", 32'(oDEC_en), 32'd1);
    check("t3_sw_pc", oDEC_pc, 32'h310);
    drive(1'b0, '0, '0, 1'b0); step();
    check("t3_rs_blk", 32'(oDEC_en), 32'd0);
    check("t3_rs_hold", oDEC_pc, 32'h310);
    iRS_full = 1'b0; step();
    check("t3_add2_en", 32'(oDEC_en), 32'd1);
    check("t3_add2_pc", oDEC_pc, 32'h314);
    step();

    // Flush with 5 queued and a same-cycle push; issue suppressed
    iROB_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), NOP, 1'b0); step();
    end
    iROB_full = 1'b0; iJP_wrong = 1'b1;
    drive(1'b1, 32'h100, NOP, 1'b0); step();
    check("t4_fl_en", 32'(oDEC_en), 32'd0);
    check("t4_fl_empty", 32'(oIQ_empty), 32'd1);
    iJP_wrong = 1'b0;
    drive(1'b0, '0, '0, 1'b0); step();
    check("t4_idle_en", 32'(oDEC_en), 32'd0);
    drive(1'b1, 32'h200, NOP, 1'b0); step();
    check("t4_push_en", 32'(oDEC_en), 32'd0);
    drive(1'b0, '0, '0, 1'b0); step();
    check("t4_first_en", 32'(oDEC_en), 32'd1);
    check("t4_first_pc", oDEC_pc, 32'h200);
    check("t4_first_empty", 32'(oIQ_empty), 32'd1);
    step();

    // Streaming at count 15 so both pointers wrap repeatedly
    iROB_full = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 32'h2000 + 32'(4 * i), NOP, 1'b0); step();
    end
    iROB_full = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 32'h2000 + 32'(4 * (15 + i)), NOP, 1'b0); step();
      check("t5_en", 32'(oDEC_en), 32'd1);
      check("t5_pc", oDEC_pc, 32'h2000 + 32'(4 * i));
    end
    check("t5_notfull", 32'(oINF_full), 32'd0);
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 40; i < 55; i++) begin
      step();
      check("t5_drain_pc", oDEC_pc, 32'h2000 + 32'(4 * i));
    end
    step();
    check("t5_end_empty", 32'(oIQ_empty), 32'd1);

    // rdy low for 3 cycles mid-stream freezes everything, including pushes
    iROB_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), NOP, 1'b0); step();
    end
    iROB_full = 1'b0;
    drive(1'b0, '0, '0, 1'b0); step();
    check("t6_pre_pc", oDEC_pc, 32'h500);
    rdy = 1'b0;
    drive(1'b1, 32'h5FC, NOP, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_frz_en", 32'(oDEC_en), 32'd1);
      check("t6_frz_pc", oDEC_pc, 32'h500);
    end
    rdy = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      check("t6_res_en", 32'(oDEC_en), 32'd1);
      check("t6_res_pc", oDEC_pc, 32'h500 + 32'(4 * i));
    end
    step();
    check("t6_end_en", 32'(oDEC_en), 32'd0);
    check("t6_end_empty", 32'(oIQ_empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
